// File: rtl/netwalk_dpl_flow_table.sv
// netwalk_dpl_flow_table
//   Masked-match flow table for the NetWalk data plane (dpl_clk domain).
//   Control side programs/deletes {key, mask, action} entries; packet side streams lookup keys
//   through a two-stage pipeline (S1: match vector, S2: lowest-index priority encode) with
//   valid/ready on both ends.
//   Optional feature macro: NETWALK_DPL_HIT_CNT_EN adds per-entry 32-bit saturating hit counters
//   and the cnt_rd_addr/cnt_rd_data read port.
module netwalk_dpl_flow_table #(
    parameter int                ENTRIES     = 64,
    parameter int                ADDR_W      = 6,
    parameter int                KEY_W       = 356,
    parameter int                ACT_W       = 16,
    parameter logic [ACT_W-1:0]  DEFAULT_ACT = '0
) (
    input  logic              dpl_clk,
    input  logic              dpl_reset_n,
    input  logic              dpl_program_enable,
    input  logic              dpl_delete_enable,
    input  logic [ADDR_W-1:0] dpl_program_addr,
    input  logic [KEY_W-1:0]  dpl_program_data,
    input  logic [KEY_W-1:0]  dpl_program_mask,
    input  logic [ACT_W-1:0]  dpl_program_action,
    output logic              dpl_cfg_err,
    input  logic              lkp_valid,
    output logic              lkp_ready,
    input  logic [KEY_W-1:0]  lkp_key,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [ADDR_W-1:0] res_index,
    output logic [ACT_W-1:0]  res_action
`ifdef NETWALK_DPL_HIT_CNT_EN
    ,
    input  logic [ADDR_W-1:0] cnt_rd_addr,
    output logic [31:0]       cnt_rd_data
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Table storage
    logic [ENTRIES-1:0] r_valid;
    logic [KEY_W-1:0]   r_key  [ENTRIES];
    logic [KEY_W-1:0]   r_mask [ENTRIES];
    logic [ACT_W-1:0]   r_act  [ENTRIES];

    // Pipeline state
    logic               r_s1_valid;
    logic [ENTRIES-1:0] r_s1_match;
    logic [ACT_W-1:0]   r_s1_act;
    logic               r_s2_valid;
    logic               r_res_hit;
    logic [ADDR_W-1:0]  r_res_index;
    logic [ACT_W-1:0]   r_res_action;
    logic               r_cfg_err;

    logic               w_cfg_any;
    logic               w_addr_ok;
    logic [IDX_W-1:0]   w_widx;
    logic               w_advance;
    logic               w_accept;
    logic [ENTRIES-1:0] w_match;
    logic [IDX_W-1:0]   w_s1_first;
    logic [ACT_W-1:0]   w_s1_act;

    // Lowest set bit of a match vector; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] f_lowest(input logic [ENTRIES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign w_cfg_any = dpl_program_enable || dpl_delete_enable;
    assign w_addr_ok = 32'(dpl_program_addr) < 32'(ENTRIES);
    assign w_widx    = IDX_W'(dpl_program_addr);
    // S1 holds whenever S2 holds, so one advance signal moves the whole pipe.
    assign w_advance = !r_s2_valid || res_ready;
    // Config cycles block lookups so no key is compared against a half-written entry.
    assign lkp_ready = w_advance && !w_cfg_any;
    assign w_accept  = lkp_valid && lkp_ready;

    // Masked compare of the incoming key against every entry.
    always_comb begin
        // NOTE: default first so every path assigns w_match and no latch is inferred.
        w_match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_match[i] = r_valid[i] && (((lkp_key ^ r_key[i]) & r_mask[i]) == '0);
        end
    end

    // Winning action is captured at S1 so later reprogramming cannot change an in-flight result.
    assign w_s1_first = f_lowest(w_match);
    assign w_s1_act   = (|w_match) ? r_act[w_s1_first] : DEFAULT_ACT;

    // Entry valid bits: delete beats program, out-of-range addresses leave the table alone.
    always_ff @(posedge dpl_clk) begin
        if (!dpl_reset_n) begin
            r_valid <= '0;
        end else if (w_addr_ok) begin
            if (dpl_delete_enable)       r_valid[w_widx] <= 1'b0;
            else if (dpl_program_enable) r_valid[w_widx] <= 1'b1;
        end
    end

    // Entry contents, written only by an in-range program that is not overridden by a delete.
    always_ff @(posedge dpl_clk) begin
        // NOTE: key/mask/action arrays carry no reset; r_valid alone decides whether they are used.
        if (dpl_program_enable && !dpl_delete_enable && w_addr_ok) begin
            r_key[w_widx]  <= dpl_program_data;
            r_mask[w_widx] <= dpl_program_mask;
            r_act[w_widx]  <= dpl_program_action;
        end
    end

    // One-cycle error pulse for program/delete at an address beyond the table.
    always_ff @(posedge dpl_clk) begin
        if (!dpl_reset_n) r_cfg_err <= 1'b0;
        else              r_cfg_err <= w_cfg_any && !w_addr_ok;
    end

    // Two-stage lookup pipeline; both stages hold while the result is stalled.
    always_ff @(posedge dpl_clk) begin
        if (!dpl_reset_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_match   <= '0;
            r_s1_act     <= DEFAULT_ACT;
            r_s2_valid   <= 1'b0;
            r_res_hit    <= 1'b0;
            r_res_index  <= '0;
            r_res_action <= DEFAULT_ACT;
        end else if (w_advance) begin
            r_s1_valid <= w_accept;
            r_s1_match <= w_match;
            r_s1_act   <= w_s1_act;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_hit    <= |r_s1_match;
                r_res_index  <= ADDR_W'(f_lowest(r_s1_match));
                r_res_action <= r_s1_act;
            end
        end
    end

    assign dpl_cfg_err = r_cfg_err;
    assign res_valid   = r_s2_valid;
    assign res_hit     = r_res_hit;
    assign res_index   = r_res_index;
    assign res_action  = r_res_action;

`ifdef NETWALK_DPL_HIT_CNT_EN
    logic [31:0] r_hit_cnt [ENTRIES];
    logic [31:0] r_cnt_rd_data;
    logic        w_res_fire;
    logic        w_cnt_rd_ok;

    assign w_res_fire  = r_s2_valid && res_ready && r_res_hit;
    assign w_cnt_rd_ok = 32'(cnt_rd_addr) < 32'(ENTRIES);

    // Saturating per-entry hit counters; (re)programming or deleting an entry clears its count.
    always_ff @(posedge dpl_clk) begin
        if (!dpl_reset_n) begin
            for (int i = 0; i < ENTRIES; i++) r_hit_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_cfg_any && w_addr_ok && (w_widx == IDX_W'(i))) begin
                    r_hit_cnt[i] <= '0;
                end else if (w_res_fire && (r_res_index == ADDR_W'(i)) && (r_hit_cnt[i] != '1)) begin
                    r_hit_cnt[i] <= r_hit_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Registered counter read port; out-of-range indices read as zero.
    always_ff @(posedge dpl_clk) begin
        if (!dpl_reset_n)     r_cnt_rd_data <= '0;
        else if (w_cnt_rd_ok) r_cnt_rd_data <= r_hit_cnt[IDX_W'(cnt_rd_addr)];
        else                  r_cnt_rd_data <= '0;
    end

    assign cnt_rd_data = r_cnt_rd_data;
`endif

endmodule

// File: tb/tb_netwalk_dpl_flow_table.sv
// tb_netwalk_dpl_flow_table
//   Self-checking bench for netwalk_dpl_flow_table: directed vector table, multi-cycle corner
//   sequences (latency, back-to-back with backpressure, cfg errors, reset mid-flight) and a
//   randomized phase scored against a behavioural table model.
//   Hit-counter checks are compiled only when NETWALK_DPL_HIT_CNT_EN is defined.
module tb_netwalk_dpl_flow_table;

    localparam int               ENTRIES = 64;
    localparam int               ADDR_W  = 7;
    localparam int               KEY_W   = 16;
    localparam int               ACT_W   = 16;
    localparam logic [ACT_W-1:0] DEF_ACT = 16'hDEAD;

    logic              clk;
    logic              dpl_reset_n;
    logic              dpl_program_enable;
    logic              dpl_delete_enable;
    logic [ADDR_W-1:0] dpl_program_addr;
    logic [KEY_W-1:0]  dpl_program_data;
    logic [KEY_W-1:0]  dpl_program_mask;
    logic [ACT_W-1:0]  dpl_program_action;
    logic              dpl_cfg_err;
    logic              lkp_valid;
    logic              lkp_ready;
    logic [KEY_W-1:0]  lkp_key;
    logic              res_valid;
    logic              res_ready;
    logic              res_hit;
    logic [ADDR_W-1:0] res_index;
    logic [ACT_W-1:0]  res_action;
`ifdef NETWALK_DPL_HIT_CNT_EN
    logic [ADDR_W-1:0] cnt_rd_addr;
    logic [31:0]       cnt_rd_data;
`endif

    netwalk_dpl_flow_table #(
        .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .KEY_W(KEY_W), .ACT_W(ACT_W), .DEFAULT_ACT(DEF_ACT)
    ) dut (
        .dpl_clk(clk),
        .dpl_reset_n(dpl_reset_n),
        .dpl_program_enable(dpl_program_enable),
        .dpl_delete_enable(dpl_delete_enable),
        .dpl_program_addr(dpl_program_addr),
        .dpl_program_data(dpl_program_data),
        .dpl_program_mask(dpl_program_mask),
        .dpl_program_action(dpl_program_action),
        .dpl_cfg_err(dpl_cfg_err),
        .lkp_valid(lkp_valid),
        .lkp_ready(lkp_ready),
        .lkp_key(lkp_key),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_hit(res_hit),
        .res_index(res_index),
        .res_action(res_action)
`ifdef NETWALK_DPL_HIT_CNT_EN
        ,
        .cnt_rd_addr(cnt_rd_addr),
        .cnt_rd_data(cnt_rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              hit;
        logic [ADDR_W-1:0] idx;
        logic [ACT_W-1:0]  act;
    } res_t;

    typedef struct {
        logic [KEY_W-1:0]  key;
        logic              hit;
        logic [ADDR_W-1:0] idx;
        logic [ACT_W-1:0]  act;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    int   rr_mode  = 0;   // 0: ready high, 1: toggle, 2: random, 3: ready low
    logic mon_en   = 1'b0;
    res_t q[$];
    res_t last_res;
    vec_t vec[12];

    // Behavioural table model
    logic             m_valid [ENTRIES];
    logic [KEY_W-1:0] m_key   [ENTRIES];
    logic [KEY_W-1:0] m_mask  [ENTRIES];
    logic [ACT_W-1:0] m_act   [ENTRIES];
    logic             exp_err;
    logic             prev_stall;
    res_t             saved_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model_lookup(input logic [KEY_W-1:0] k);
        res_t r;
        r = '{hit: 1'b0, idx: '0, act: DEF_ACT};
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i] && (((k ^ m_key[i]) & m_mask[i]) == '0)) begin
                r = '{hit: 1'b1, idx: ADDR_W'(i), act: m_act[i]};
                return r;
            end
        end
        return r;
    endfunction

    // Result readiness pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ~res_ready;
            2:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (!dpl_reset_n) begin
            q.delete();
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            exp_err    = 1'b0;
            prev_stall = 1'b0;
        end else if (mon_en) begin
            check("cfg_err", dpl_cfg_err, exp_err);
            if (prev_stall) begin
                check("stall_valid", res_valid, 1);
                check("stall_data", {res_hit, res_index, res_action}, saved_res);
            end
            if (dpl_program_enable || dpl_delete_enable)
                check("lkp_ready_cfg", lkp_ready, 0);
            else if (!res_valid || res_ready)
                check("lkp_ready_free", lkp_ready, 1);
            if (res_valid && res_ready) begin
                check("res_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    res_t e;
                    e = q.pop_front();
                    check("sb_hit", res_hit, e.hit);
                    check("sb_index", res_index, e.idx);
                    check("sb_action", res_action, e.act);
                end
                last_res = '{hit: res_hit, idx: res_index, act: res_action};
                n_pops++;
            end
            prev_stall = res_valid && !res_ready;
            saved_res  = '{hit: res_hit, idx: res_index, act: res_action};
            if (lkp_valid && lkp_ready) q.push_back(model_lookup(lkp_key));
            exp_err = (dpl_program_enable || dpl_delete_enable) && (int'(dpl_program_addr) >= ENTRIES);
            if ((dpl_program_enable || dpl_delete_enable) && (int'(dpl_program_addr) < ENTRIES)) begin
                if (dpl_delete_enable) begin
                    m_valid[dpl_program_addr] = 1'b0;
                end else begin
                    m_valid[dpl_program_addr] = 1'b1;
                    m_key[dpl_program_addr]   = dpl_program_data;
                    m_mask[dpl_program_addr]  = dpl_program_mask;
                    m_act[dpl_program_addr]   = dpl_program_action;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input bit p, input bit d, input int a, input logic [KEY_W-1:0] k,
                       input logic [KEY_W-1:0] m, input logic [ACT_W-1:0] act);
        dpl_program_enable = p;
        dpl_delete_enable  = d;
        dpl_program_addr   = ADDR_W'(a);
        dpl_program_data   = k;
        dpl_program_mask   = m;
        dpl_program_action = act;
        sync();
        dpl_program_enable = 1'b0;
        dpl_delete_enable  = 1'b0;
    endtask

    task automatic send_lkp(input logic [KEY_W-1:0] k);
        bit acc;
        acc       = 1'b0;
        lkp_valid = 1'b1;
        lkp_key   = k;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (lkp_ready) begin
                acc = 1'b1;
                break;
            end
        end
        check("lkp_accept", acc, 1);
        sync();
        lkp_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !res_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", done, 1);
        sync();
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_lkp(vec[i].key);
            drain();
            check($sformatf("vec%0d_hit", i), last_res.hit, vec[i].hit);
            check($sformatf("vec%0d_index", i), last_res.idx, vec[i].idx);
            check($sformatf("vec%0d_action", i), last_res.act, vec[i].act);
        end
    endtask

`ifdef NETWALK_DPL_HIT_CNT_EN
    task automatic read_cnt(input string name, input int a, input logic [31:0] exp);
        cnt_rd_addr = ADDR_W'(a);
        @(posedge clk);
        @(negedge clk);
        check(name, cnt_rd_data, exp);
        sync();
    endtask
`endif

    initial begin
        vec[0]  = '{16'h00AB, 1'b1, 7'd2, 16'h0022};
        vec[1]  = '{16'h00A5, 1'b1, 7'd2, 16'h0022};
        vec[2]  = '{16'h00BB, 1'b0, 7'd0, DEF_ACT};
        vec[3]  = '{16'h12AB, 1'b1, 7'd2, 16'h0022};
        vec[4]  = '{16'h00AB, 1'b1, 7'd5, 16'h0011};
        vec[5]  = '{16'h00A5, 1'b0, 7'd0, DEF_ACT};
        vec[6]  = '{16'hFFAB, 1'b1, 7'd5, 16'h0011};
        vec[7]  = '{16'h0777, 1'b0, 7'd0, DEF_ACT};
        vec[8]  = '{16'h0640, 1'b0, 7'd0, DEF_ACT};
        vec[9]  = '{16'h00AB, 1'b1, 7'd5, 16'h0011};
        vec[10] = '{16'h00AB, 1'b0, 7'd0, DEF_ACT};
        vec[11] = '{16'h100A, 1'b0, 7'd0, DEF_ACT};

        dpl_reset_n = 1'b0;
        dpl_program_enable = 1'b0; dpl_delete_enable = 1'b0; dpl_program_addr = '0;
        dpl_program_data = '0; dpl_program_mask = '0; dpl_program_action = '0;
        lkp_valid = 1'b0; lkp_key = '0; res_ready = 1'b1;
`ifdef NETWALK_DPL_HIT_CNT_EN
        cnt_rd_addr = '0;
`endif
        repeat (3) sync();
        dpl_reset_n = 1'b1;
        mon_en      = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_hit", res_hit, 0);
        check("rst_res_index", res_index, 0);
        check("rst_res_action", res_action, DEF_ACT);
        check("rst_cfg_err", dpl_cfg_err, 0);
        sync();

        // Empty table miss and two-cycle latency
        send_lkp(16'h0123);
        @(negedge clk);
        check("lat_s1_res_valid", res_valid, 0);
        @(negedge clk);
        check("lat_s2_res_valid", res_valid, 1);
        check("lat_res_hit", res_hit, 0);
        check("lat_res_index", res_index, 0);
        check("lat_res_action", res_action, DEF_ACT);
        drain();

        // Priority among overlapping entries, then delete of the winner
        cfg(1, 0, 5, 16'h00AB, 16'h00FF, 16'h0011);
        cfg(1, 0, 2, 16'h00A0, 16'h00F0, 16'h0022);
        run_vecs(0, 3);
        cfg(0, 1, 2, '0, '0, '0);
        run_vecs(4, 6);

        // Back-to-back with alternating result backpressure
        for (int i = 10; i < 26; i++) cfg(1, 0, i, KEY_W'(16'h1000 + i), 16'hFFFF, ACT_W'(16'h0100 + i));
        begin
            int p0;
            p0 = n_pops;
            rr_mode = 1;
            for (int i = 0; i < 16; i++) send_lkp(KEY_W'(16'h100A + i));
            drain();
            rr_mode = 0;
            check("b2b_count", n_pops - p0, 16);
        end
        sync();

        // Program+delete collision and out-of-range addresses
        cfg(1, 0, 7, 16'h0777, 16'hFFFF, 16'h0077);
        cfg(1, 1, 7, 16'h0777, 16'hFFFF, 16'h0077);
        cfg(1, 0, 64, 16'h0640, 16'hFFFF, 16'h0064);
        @(negedge clk);
        check("cfg_err_pulse_hi", dpl_cfg_err, 1);
        @(negedge clk);
        check("cfg_err_pulse_lo", dpl_cfg_err, 0);
        sync();
        cfg(0, 1, 69, '0, '0, '0);
        run_vecs(7, 9);

`ifdef NETWALK_DPL_HIT_CNT_EN
        // Hit counters: count, clear on reprogram, saturation
        cfg(1, 0, 5, 16'h00AB, 16'h00FF, 16'h0011);
        repeat (3) begin send_lkp(16'h00AB); drain(); end
        read_cnt("cnt_three", 5, 32'd3);
        cfg(1, 0, 5, 16'h00AB, 16'h00FF, 16'h0011);
        read_cnt("cnt_cleared", 5, 32'd0);
        dut.r_hit_cnt[5] = 32'hFFFF_FFFE;
        repeat (2) begin send_lkp(16'h00AB); drain(); end
        read_cnt("cnt_saturated", 5, 32'hFFFF_FFFF);
        read_cnt("cnt_out_of_range", 64, 32'd0);
`endif

        // Reset with two lookups in flight
        rr_mode = 3;
        sync(); sync();
        send_lkp(16'h00AB);
        send_lkp(16'h100A);
        dpl_reset_n = 1'b0;
        sync(); sync();
        dpl_reset_n = 1'b1;
        rr_mode     = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_res_valid", res_valid, 0);
        end
        sync();
        run_vecs(10, 11);

        // Randomized traffic against the model
        rr_mode = 2;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 99) < 20) begin
                int op, a, mc;
                logic [KEY_W-1:0] m;
                op = $urandom_range(0, 3);
                a  = $urandom_range(0, ENTRIES + 7);
                mc = $urandom_range(0, 9);
                if (mc == 0)     m = '0;
                else if (mc < 5) m = '1;
                else if (mc < 8) m = 16'hFF00;
                else             m = KEY_W'($urandom);
                cfg(op != 2, op >= 2, a, KEY_W'($urandom), m, ACT_W'($urandom));
            end else begin
                logic [KEY_W-1:0] k;
                if ($urandom_range(0, 1) == 1) k = m_key[$urandom_range(0, ENTRIES - 1)] ^ KEY_W'($urandom_range(0, 3));
                else                           k = KEY_W'($urandom);
                if ($isunknown(k)) k = KEY_W'($urandom);
                send_lkp(k);
            end
        end
        rr_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
